// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation controller: hands out sequential ROB IDs per decode group,
// tracks head/tail/occupancy, rewinds the tail on flush and blocks allocation while recovering.
module rob_alloc_ctrl #(
  parameter int ISSUE_WIDTH_MAX  = 4,
  parameter int RETIRE_WIDTH_MAX = 4,
  parameter int ROB_SIZE         = 32,
  parameter int ROB_SIZE_CLOG    = 5,
  parameter int RECOVER_CYC      = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ISSUE_WIDTH_MAX-1:0]                instr_val_id,
  input  logic [$clog2(RETIRE_WIDTH_MAX+1)-1:0]     ret_cnt,
  input  logic                                      flush,
  input  logic [ROB_SIZE_CLOG-1:0]                  flush_robid,
  output logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0]  rob_is_ptr,
  output logic                                      alloc_ok,
  output logic [ROB_SIZE_CLOG-1:0]                  rob_head,
  output logic [ROB_SIZE_CLOG-1:0]                  rob_tail,
  output logic [ROB_SIZE_CLOG:0]                    rob_cnt,
  output logic                                      rob_full,
  output logic                                      rob_empty,
  output logic                                      recovering
);

  localparam int PW = ROB_SIZE_CLOG;
  localparam int CW = ROB_SIZE_CLOG + 1;
  localparam int NW = $clog2(ISSUE_WIDTH_MAX + 1);
  localparam int RW = $clog2(RECOVER_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ROB_SIZE);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [RW-1:0] REC_ONE = RW'(1);
  localparam logic [ISSUE_WIDTH_MAX-1:0] VAL_ONE = ISSUE_WIDTH_MAX'(1);

  typedef enum logic {ST_RUN, ST_RECOVER} state_e;

  state_e         state_q;
  logic [RW-1:0]  rec_q;
  logic           recovering_q;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d, flush_off;
  logic [CW-1:0]  cnt_q, cnt_d, n_alloc_w, ret_w;
  logic [NW-1:0]  n_alloc;

  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      n_alloc = n_alloc + NW'(instr_val_id[i]);
    end
  end

  assign n_alloc_w = CW'(n_alloc);
  assign ret_w     = CW'(ret_cnt);

  // Space check uses registered occupancy only; same-cycle retires do not help.
  assign alloc_ok = !rst && (state_q == ST_RUN) && !flush && (n_alloc != '0) &&
                    (n_alloc_w <= (CNT_MAX - cnt_q));

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      rob_is_ptr[i*PW +: PW] = tail_q + PW'(i);
    end
  end

  always_comb begin
    head_d    = head_q + PW'(ret_cnt);
    flush_off = flush_robid - head_d;
    tail_d    = tail_q;
    cnt_d     = cnt_q - ret_w;
    if (flush) begin
      tail_d = flush_robid + PTR_ONE;
      cnt_d  = {1'b0, flush_off} + CNT_ONE;
    end else if (alloc_ok) begin
      tail_d = tail_q + PW'(n_alloc);
      cnt_d  = cnt_q + n_alloc_w - ret_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Recovery timer counts down to 1; a flush in any state reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      rec_q        <= '0;
      recovering_q <= 1'b0;
    end else if (flush) begin
      state_q      <= ST_RECOVER;
      rec_q        <= RW'(RECOVER_CYC);
      recovering_q <= 1'b1;
    end else if (state_q == ST_RECOVER) begin
      rec_q <= rec_q - REC_ONE;
      if (rec_q == REC_ONE) begin
        state_q      <= ST_RUN;
        recovering_q <= 1'b0;
      end
    end
  end

  assign rob_head   = head_q;
  assign rob_tail   = tail_q;
  assign rob_cnt    = cnt_q;
  assign rob_full   = (cnt_q == CNT_MAX);
  assign rob_empty  = (cnt_q == '0);
  assign recovering = recovering_q;

  a_thermo: assert property (@(posedge clk) disable iff (rst)
    ((instr_val_id & (instr_val_id + VAL_ONE)) == '0));
  a_ret: assert property (@(posedge clk) disable iff (rst) (ret_w <= cnt_q));
  a_flush: assert property (@(posedge clk) disable iff (rst)
    flush |-> ({1'b0, flush_off} < (cnt_q - ret_w)));

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Randomized bench for rob_alloc_ctrl: an occupancy/pointer model in plain integers is
// compared against every DUT output each cycle, with literal checks pinning key scenarios.
module tb_rob_alloc_ctrl;
  localparam int RS = 32;
  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  instr_val_id;
  logic [2:0]  ret_cnt;
  logic        flush;
  logic [4:0]  flush_robid;
  logic [19:0] rob_is_ptr;
  logic        alloc_ok;
  logic [4:0]  rob_head, rob_tail;
  logic [5:0]  rob_cnt;
  logic        rob_full, rob_empty, recovering;

  rob_alloc_ctrl dut (
    .clk(clk), .rst(rst), .instr_val_id(instr_val_id), .ret_cnt(ret_cnt),
    .flush(flush), .flush_robid(flush_robid), .rob_is_ptr(rob_is_ptr),
    .alloc_ok(alloc_ok), .rob_head(rob_head), .rob_tail(rob_tail), .rob_cnt(rob_cnt),
    .rob_full(rob_full), .rob_empty(rob_empty), .recovering(recovering)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_head, m_tail, m_cnt, m_rec;
  int cur_n, cur_ret, cur_rid;
  bit cur_fl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int exp_ok();
    return (!cur_fl && m_rec == 0 && cur_n > 0 && cur_n <= RS - m_cnt) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_cnt = 0; m_rec = 0;
  endtask

  task automatic drive(input int n, input int r, input bit f, input int rid);
    instr_val_id = 4'((1 << n) - 1);
    ret_cnt      = 3'(r);
    flush        = f;
    flush_robid  = 5'(rid);
    cur_n = n; cur_ret = r; cur_fl = f; cur_rid = rid;
  endtask

  task automatic check_all();
    chk("alloc_ok", {31'd0, alloc_ok}, exp_ok());
    chk("rob_head", {27'd0, rob_head}, m_head);
    chk("rob_tail", {27'd0, rob_tail}, m_tail);
    chk("rob_cnt", {26'd0, rob_cnt}, m_cnt);
    chk("rob_full", {31'd0, rob_full}, (m_cnt == RS) ? 1 : 0);
    chk("rob_empty", {31'd0, rob_empty}, (m_cnt == 0) ? 1 : 0);
    chk("recovering", {31'd0, recovering}, (m_rec > 0) ? 1 : 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("is_ptr%0d", i), {27'd0, rob_is_ptr[i*5 +: 5]}, (m_tail + i) % RS);
  endtask

  task automatic adv();
    int hn, okv;
    @(posedge clk);
    okv = exp_ok();
    hn  = (m_head + cur_ret) % RS;
    if (cur_fl) begin
      m_tail = (cur_rid + 1) % RS;
      m_cnt  = ((cur_rid - hn + RS) % RS) + 1;
      m_rec  = RC;
    end else begin
      if (okv != 0) begin
        m_tail = (m_tail + cur_n) % RS;
        m_cnt  = m_cnt + cur_n;
      end
      m_cnt = m_cnt - cur_ret;
      if (m_rec > 0) m_rec--;
    end
    m_head = hn;
    @(negedge clk);
  endtask

  task automatic cyc(input int n, input int r, input bit f, input int rid);
    drive(n, r, f, rid);
    #1 check_all();
    adv();
  endtask

  task automatic drain();
    while (m_cnt > 0) cyc(0, min_i(4, m_cnt), 1'b0, 0);
  endtask

  task automatic fill_to(input int t);
    int d;
    while (m_tail != t) begin
      d = (t - m_tail + RS) % RS;
      cyc(min_i(4, d), 0, 1'b0, 0);
    end
  endtask

  task automatic goto_pos(input int h, input int t);
    drain(); fill_to(h); drain(); fill_to(t);
  endtask

  initial begin
    int k, r, rid, hn, surv;
    rst = 1'b1;
    model_reset();
    drive(0, 0, 1'b0, 0);
    #1;
    chk("rst_alloc_ok", {31'd0, alloc_ok}, 0);
    chk("rst_empty", {31'd0, rob_empty}, 1);
    chk("rst_ptr", {12'd0, rob_is_ptr}, {12'd0, 5'd3, 5'd2, 5'd1, 5'd0});
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // First group after reset
    drive(3, 0, 1'b0, 0);
    #1;
    chk("t1_ptr", {12'd0, rob_is_ptr}, {12'd0, 5'd3, 5'd2, 5'd1, 5'd0});
    chk("t1_ok", {31'd0, alloc_ok}, 1);
    check_all();
    adv();
    drive(0, 0, 1'b0, 0);
    #1;
    chk("t1_tail", {27'd0, rob_tail}, 3);
    chk("t1_cnt", {26'd0, rob_cnt}, 3);
    chk("t1_ptr0", {27'd0, rob_is_ptr[4:0]}, 3);

    // Near-full: retire does not free space in the same cycle
    fill_to(30);
    drive(3, 0, 1'b0, 0);
    #1 chk("nf_ok0", {31'd0, alloc_ok}, 0);
    check_all(); adv();
    chk("nf_cnt30", {26'd0, rob_cnt}, 30);
    drive(3, 1, 1'b0, 0);
    #1 chk("nf_ok_ret", {31'd0, alloc_ok}, 0);
    check_all(); adv();
    chk("nf_cnt29", {26'd0, rob_cnt}, 29);
    drive(3, 0, 1'b0, 0);
    #1 chk("nf_ok1", {31'd0, alloc_ok}, 1);
    check_all(); adv();
    chk("full_cnt", {26'd0, rob_cnt}, 32);
    chk("full_flag", {31'd0, rob_full}, 1);
    cyc(1, 0, 1'b0, 0);

    // Wrap-around
    goto_pos(30, 30);
    drive(4, 0, 1'b0, 0);
    #1 chk("wrap_ptr", {12'd0, rob_is_ptr}, {12'd0, 5'd1, 5'd0, 5'd31, 5'd30});
    check_all(); adv();
    chk("wrap_tail", {27'd0, rob_tail}, 2);
    chk("wrap_cnt", {26'd0, rob_cnt}, 4);

    // Flush with same-cycle retire
    goto_pos(5, 20);
    cyc(0, 2, 1'b1, 9);
    chk("fl_head", {27'd0, rob_head}, 7);
    chk("fl_tail", {27'd0, rob_tail}, 10);
    chk("fl_cnt", {26'd0, rob_cnt}, 3);
    chk("fl_rec", {31'd0, recovering}, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1'b0, 0);
      #1 chk($sformatf("fl_ok_c%0d", i), {31'd0, alloc_ok}, (i == 2) ? 1 : 0);
      check_all(); adv();
    end

    // Second flush in the first recovery cycle
    cyc(0, 0, 1'b1, 8);
    drive(1, 0, 1'b1, 7);
    #1 chk("ff_rec", {31'd0, recovering}, 1);
    check_all(); adv();
    chk("ff_tail", {27'd0, rob_tail}, 8);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1'b0, 0);
      #1 chk($sformatf("ff_ok_c%0d", i), {31'd0, alloc_ok}, (i == 2) ? 1 : 0);
      check_all(); adv();
    end

    // Asynchronous reset mid-allocation
    fill_to(17);
    drive(4, 0, 1'b0, 0);
    #1 check_all();
    #2 rst = 1'b1;
    #1;
    chk("ar_head", {27'd0, rob_head}, 0);
    chk("ar_tail", {27'd0, rob_tail}, 0);
    chk("ar_cnt", {26'd0, rob_cnt}, 0);
    chk("ar_empty", {31'd0, rob_empty}, 1);
    chk("ar_ok", {31'd0, alloc_ok}, 0);
    @(posedge clk);
    #1 chk("ar_ok_hold", {31'd0, alloc_ok}, 0);
    chk("ar_tail_hold", {27'd0, rob_tail}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      k = $urandom_range(0, 4);
      r = ($urandom_range(0, 2) == 0) ? $urandom_range(0, min_i(4, m_cnt)) : 0;
      surv = m_cnt - r;
      if (surv >= 1 && $urandom_range(0, 11) == 0) begin
        hn  = (m_head + r) % RS;
        rid = (hn + $urandom_range(0, surv - 1)) % RS;
        cyc(k, r, 1'b1, rid);
      end else begin
        cyc(k, r, 1'b0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
- Reorder-buffer allocation controller in the ID stage of the superscalar core.
- Hands out sequential ROB IDs (rob_is_ptr) to each decode group and advances the tail on allocation and the head on retire.
- Rewinds the tail on branch-mispredict flush and runs a short recovery bubble afterwards.
- Issues a single all-or-nothing alloc_ok per group to the fetch/decode stall logic.

Parameters:
ISSUE_WIDTH_MAX, 4, decode/allocate lanes per cycle
RETIRE_WIDTH_MAX, 4, maximum retirements per cycle
ROB_SIZE, 32, ROB entries; must be a power of 2 and >= ISSUE_WIDTH_MAX
ROB_SIZE_CLOG, 5, log2(ROB_SIZE)
RECOVER_CYC, 2, allocation-blocked cycles after a flush (>=1)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-high reset
instr_val_id  in  ISSUE_WIDTH_MAX  valid lanes of the decode group; thermometer from bit 0
ret_cnt  in  $clog2(RETIRE_WIDTH_MAX+1)  entries retiring this cycle, oldest first
flush  in  1  mispredict flush
flush_robid  in  ROB_SIZE_CLOG  robid of the youngest surviving entry
rob_is_ptr  out  ISSUE_WIDTH_MAX x ROB_SIZE_CLOG  ROB ID per lane
alloc_ok  out  1  group accepted this cycle
rob_head  out  ROB_SIZE_CLOG  oldest occupied entry
rob_tail  out  ROB_SIZE_CLOG  next free entry
rob_cnt  out  ROB_SIZE_CLOG+1  occupancy, 0..ROB_SIZE
rob_full  out  1  rob_cnt == ROB_SIZE
rob_empty  out  1  rob_cnt == 0
recovering  out  1  FSM in RECOVER

Behaviour:
- Reset (async, rst=1): head=0, tail=0, cnt=0, FSM=RUN, recovery counter=0.
  - Outputs during reset: alloc_ok=0, rob_empty=1, rob_full=0, recovering=0, rob_is_ptr[i]=i.
- rob_is_ptr[i] = (tail + i) mod ROB_SIZE. Combinational from the registered tail. Driven on every lane regardless of valid.
- n_alloc = popcount(instr_val_id).
  - A non-thermometer mask is illegal; flag it with an assertion.
- alloc_ok = (FSM==RUN) && !flush && (n_alloc != 0) && (n_alloc <= ROB_SIZE - cnt).
  - Uses registered cnt only. Same-cycle retires do not free space for allocation.
  - All-or-nothing: a partial group is never allocated.
- Allocation (alloc_ok=1): tail += n_alloc mod ROB_SIZE at the clock edge; cnt += n_alloc.
- Retire: head += ret_cnt mod ROB_SIZE; cnt -= ret_cnt.
  - ret_cnt > cnt is illegal (assertion).
  - Retire is applied in every FSM state, including during flush.
- Simultaneous allocate and retire: cnt_next = cnt + n_alloc - ret_cnt. Head and tail both update.
- Flush (flush=1, any state):
  - Retire is applied first: head_n = head + ret_cnt.
  - tail_next = flush_robid + 1 mod ROB_SIZE.
  - cnt_next = ((flush_robid - head_n) mod ROB_SIZE) + 1.
  - flush_robid must lie in [head_n, tail-1] (assertion).
  - A flush that leaves the ROB empty is signalled by the retire path, not by flush.
  - No allocation in the flush cycle.
  - FSM -> RECOVER; recovery counter loads RECOVER_CYC.
- FSM:
  - RUN: stay unless flush.
  - RECOVER: counter decrements each cycle; alloc_ok=0; recovering=1. When counter==1 and no new flush -> RUN.
  - A flush while in RECOVER reloads the counter.
- Wrap-around: all pointer arithmetic is mod ROB_SIZE via natural truncation. cnt distinguishes full from empty when head==tail.
- Full/empty:
  - rob_full, rob_empty and rob_cnt are registered-state derived, combinational.
  - When full, alloc_ok=0 for any n_alloc>0.
  - n_alloc=0 gives alloc_ok=0 and no state change.
- Latency: alloc_ok is same-cycle combinational. IDs advance at the next rising edge.

Test Plan:
- Reset then instr_val_id=4'b0111 -> rob_is_ptr={3,2,1,0}, alloc_ok=1; next cycle tail=3, cnt=3, rob_is_ptr[0]=3.
- Fill to cnt=30, instr_val_id=4'b0111 -> alloc_ok=0, no state change. Same group with ret_cnt=1 -> alloc_ok=0; next cycle cnt=29. Group then accepted -> cnt=32, rob_full=1.
- Wrap: head=tail=30, cnt=0, instr_val_id=4'b1111 -> rob_is_ptr={1,0,31,30}; next cycle tail=2, cnt=4.
- Flush with head=5, tail=20, ret_cnt=2, flush_robid=9 -> next cycle head=7, tail=10, cnt=3, recovering=1. alloc_ok=0 for 2 cycles, then 1.
- Flush issued again in the 1st RECOVER cycle -> recovery extends to 2 cycles after the second flush; tail follows the second flush_robid.
- Assert rst mid-allocation (tail=17) asynchronously -> head=tail=cnt=0 immediately, rob_empty=1, alloc_ok=0 until rst deasserts.
